seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_pkg.sv | 19 +
 rtl/seg7_decode.sv | 11 +
 rtl/seg7_scan_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment scan controller:
// scan state encodings, the blank pattern and the active-low hex glyph table.
package seg7_pkg;

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low, bit0 = a ... bit6 = g; b and d use lower-case glyphs.
    localparam logic [6:0] HEX_GLYPH [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_GLYPH[nibble_i];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment scanner with blanking gaps, leading-zero
// suppression and a shadow register that only updates the display at frame wrap.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int BLANK_CYC  = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic                    i_lz_blank,
    input  logic                    i_load_valid,
    input  logic [4*NUM_DIGITS-1:0] i_load_data,
    input  logic [NUM_DIGITS-1:0]   i_load_dp,
    output logic                    o_load_ready,
    output logic [NUM_DIGITS-1:0]   o_anode,
    output logic [6:0]              o_seg,
    output logic                    o_dp,
    output logic                    o_frame
);

    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    logic [1:0]              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    wrap_s;

    logic [4*NUM_DIGITS-1:0] shadow_q, active_q;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, active_dp_q;
    logic                    pending_q, pending_d;
    logic                    ready_q, ready_d;
    logic                    accept_s, xfer_s;

    logic [3:0]              nibble_s;
    logic [6:0]              glyph_s;
    logic [NUM_DIGITS-1:0]   lead_zero_s;
    logic                    suppress_s;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    frame_q;

    // Scan sequencer next-state: OFF -> BLANK -> DRIVE per digit, disable wins.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wrap_s  = 1'b0;
        if (!i_en) begin
            state_d = ST_OFF;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_BLANK;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_DRIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == SCAN_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d  = '0;
                            wrap_s = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Load handshake: ready reopens only the cycle after the shadow reaches the display.
    always_comb begin
        accept_s = i_load_valid && ready_q;
        xfer_s   = pending_q && ((state_q == ST_OFF) || wrap_s);
        if (accept_s) begin
            pending_d = 1'b1;
        end else if (xfer_s) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        ready_d = ~(pending_d | pending_q);
    end

    assign nibble_s = active_q[4*idx_q +: 4];

    seg7_decode u_decode (
        .nibble_i (nibble_s),
        .seg_o    (glyph_s)
    );

    // lead_zero_s[i] is set when digit i and every digit above it are zero.
    always_comb begin
        lead_zero_s = '0;
        lead_zero_s[NUM_DIGITS-1] = (active_q[4*(NUM_DIGITS-1) +: 4] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            lead_zero_s[i] = lead_zero_s[i+1] && (active_q[4*i +: 4] == 4'h0);
        end
        suppress_s = i_lz_blank && (idx_q != '0) && lead_zero_s[idx_q];
    end

    // Output pattern for the current state; gating with i_en darkens the display at once.
    always_comb begin
        anode_d = '1;
        seg_d   = SEG_BLANK;
        dp_d    = 1'b1;
        if (i_en && (state_q == ST_DRIVE)) begin
            anode_d[idx_q] = 1'b0;
            seg_d          = suppress_s ? SEG_BLANK : glyph_s;
            dp_d           = ~active_dp_q[idx_q];
        end else begin
            anode_d = '1;
        end
    end

    // Sequencer, data path and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_OFF;
            idx_q       <= '0;
            cnt_q       <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            active_q    <= '0;
            active_dp_q <= '0;
            pending_q   <= 1'b0;
            ready_q     <= 1'b1;
            anode_q     <= '1;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
            frame_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            ready_q   <= ready_d;
            if (accept_s) begin
                shadow_q    <= i_load_data;
                shadow_dp_q <= i_load_dp;
            end
            if (xfer_s) begin
                active_q    <= shadow_q;
                active_dp_q <= shadow_dp_q;
            end
            anode_q <= anode_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            frame_q <= wrap_s;
        end
    end

    assign o_load_ready = ready_q;
    assign o_anode      = anode_q;
    assign o_seg        = seg_q;
    assign o_dp         = dp_q;
    assign o_frame      = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: positional scan model checked every
// cycle, plus directed literal expectations for the documented scenarios.
module tb_seg7_scan_ctrl;

    localparam int ND    = 4;
    localparam int SD    = 4;
    localparam int BC    = 1;
    localparam int SLOT  = SD + BC;
    localparam int FRAME = SLOT * ND;

    logic          clk = 1'b0;
    logic          rst, en, lz, lv;
    logic [15:0]   ld;
    logic [3:0]    ldp;
    logic          ready, dp, frame;
    logic [3:0]    anode;
    logic [6:0]    seg;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] glyph [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    seg7_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_lz_blank   (lz),
        .i_load_valid (lv),
        .i_load_data  (ld),
        .i_load_dp    (ldp),
        .o_load_ready (ready),
        .o_anode      (anode),
        .o_seg        (seg),
        .o_dp         (dp),
        .o_frame      (frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_run counts consecutive enabled edges; screen position is plain arithmetic on it.
    int          m_run;
    logic [15:0] m_shadow, m_active;
    logic [3:0]  m_sdp, m_adp;
    bit          m_pend, m_ready;

    initial begin
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp, e_fr;
        bit         xfer;
        int         p, dig;
        logic [3:0] one;
        logic [15:0] upper;
        one = 4'b0001;
        m_run = 0; m_shadow = '0; m_active = '0; m_sdp = '0; m_adp = '0;
        m_pend = 1'b0; m_ready = 1'b1;
        forever begin
            @(posedge clk);
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fr = 1'b0; xfer = 1'b0;
            if (rst) begin
                m_run = 0; m_shadow = '0; m_active = '0; m_sdp = '0; m_adp = '0;
                m_pend = 1'b0; m_ready = 1'b1;
            end else begin
                if (en && m_run >= 1) begin
                    p   = (m_run - 1) % FRAME;
                    dig = p / SLOT;
                    if ((p % SLOT) >= BC) begin
                        e_an  = ~(one << dig);
                        upper = m_active >> (4 * dig);
                        if (lz && dig != 0 && upper == 16'h0) e_seg = 7'h7F;
                        else e_seg = glyph[upper[3:0]];
                        e_dp = ~m_adp[dig];
                    end
                end
                if (en && m_run >= FRAME && (m_run % FRAME) == 0) e_fr = 1'b1;
                if (m_pend && (m_run == 0 || e_fr)) begin
                    m_active = m_shadow; m_adp = m_sdp; m_pend = 1'b0; xfer = 1'b1;
                end else if (lv && m_ready) begin
                    m_shadow = ld; m_sdp = ldp; m_pend = 1'b1;
                end
                m_ready = !m_pend && !xfer;
                m_run   = en ? m_run + 1 : 0;
            end
            #1;
            check("anode", 32'(anode), 32'(e_an));
            check("seg",   32'(seg),   32'(e_seg));
            check("dp",    32'(dp),    32'(e_dp));
            check("frame", 32'(frame), 32'(e_fr));
            check("ready", 32'(ready), 32'(m_ready));
        end
    end

    task automatic wait_frame();
        bit seen = 1'b0;
        for (int i = 0; i < 3 * FRAME && !seen; i++) begin
            @(posedge clk); #1;
            if (frame) seen = 1'b1;
        end
        check("frame_seen", 32'(seen), 32'd1);
    endtask

    task automatic pin(input string name, input logic [3:0] e_an, input logic [6:0] e_seg);
        check({name, "_anode"}, 32'(anode), 32'(e_an));
        check({name, "_seg"},   32'(seg),   32'(e_seg));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; lz = 1'b0; lv = 1'b0; ld = '0; ldp = '0;
        repeat (3) @(posedge clk); #1;
        pin("reset", 4'hF, 7'h7F);
        check("reset_dp", 32'(dp), 32'd1);
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_frame", 32'(frame), 32'd0);
        @(negedge clk) rst = 1'b0;

        // Load while OFF transfers on the next edge
        @(negedge clk) begin lv = 1'b1; ld = 16'h12AF; ldp = 4'b0100; end
        @(negedge clk) lv = 1'b0;
        check("off_load_ready_low", 32'(ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("off_load_ready_back", 32'(ready), 32'd1);

        en = 1'b1;
        repeat (3) @(posedge clk); #1;
        pin("d0_F", 4'b1110, 7'h0E);
        check("d0_dp", 32'(dp), 32'd1);
        repeat (5) @(posedge clk); #1;
        pin("d1_A", 4'b1101, 7'h08);
        repeat (5) @(posedge clk); #1;
        pin("d2_2", 4'b1011, 7'h24);
        check("d2_dp", 32'(dp), 32'd0);
        repeat (5) @(posedge clk); #1;
        pin("d3_1", 4'b0111, 7'h79);
        repeat (3) @(posedge clk); #1;
        check("frame_at_20", 32'(frame), 32'd1);
        @(posedge clk); #1;
        check("frame_one_cycle", 32'(frame), 32'd0);

        // Mid-frame load; the held-valid second offer must be ignored
        @(negedge clk) begin lv = 1'b1; ld = 16'h1234; ldp = 4'b0000; end
        @(negedge clk) ld = 16'hBEEF;
        check("midframe_ready_low", 32'(ready), 32'd0);
        @(negedge clk) lv = 1'b0;
        wait_frame();
        check("ready_low_on_frame", 32'(ready), 32'd0);
        @(posedge clk); #1;
        check("ready_after_frame", 32'(ready), 32'd1);
        @(posedge clk); #1;
        pin("new_d0_4", 4'b1110, 7'h19);

        // Leading-zero suppression
        @(negedge clk) begin lz = 1'b1; lv = 1'b1; ld = 16'h0070; ldp = 4'b0000; end
        @(negedge clk) lv = 1'b0;
        wait_frame();
        repeat (2) @(posedge clk); #1;
        pin("lz_d0", 4'b1110, 7'h40);
        repeat (5) @(posedge clk); #1;
        pin("lz_d1", 4'b1101, 7'h78);
        repeat (5) @(posedge clk); #1;
        pin("lz_d2", 4'b1011, 7'h7F);
        repeat (5) @(posedge clk); #1;
        pin("lz_d3", 4'b0111, 7'h7F);

        // Disable during digit 2, then restart
        wait_frame();
        repeat (12) @(posedge clk); #1;
        check("pre_disable_anode", 32'(anode), 32'(4'b1011));
        @(negedge clk) en = 1'b0;
        @(posedge clk); #1;
        pin("disabled", 4'hF, 7'h7F);
        repeat (3) @(negedge clk);
        en = 1'b1;
        repeat (3) @(posedge clk); #1;
        pin("restart_d0", 4'b1110, 7'h40);

        // Reset with a pending load discards it
        @(negedge clk) begin lz = 1'b0; lv = 1'b1; ld = 16'hABCD; ldp = 4'hF; end
        @(negedge clk) begin lv = 1'b0; rst = 1'b1; en = 1'b0; end
        #1;
        pin("midload_reset", 4'hF, 7'h7F);
        check("midload_reset_ready", 32'(ready), 32'd1);
        check("midload_reset_dp", 32'(dp), 32'd1);
        @(negedge clk) begin rst = 1'b0; en = 1'b1; end
        repeat (3) @(posedge clk); #1;
        pin("post_reset_d0", 4'b1110, 7'h40);
        check("post_reset_dp", 32'(dp), 32'd1);
        repeat (25) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
